// File: rtl/ex_div_sequencer_pkg.sv
// rtl/ex_div_sequencer_pkg.sv - shared core definitions for the EX-stage divider
package ex_div_sequencer_pkg;

  // alu_ctrl layout: {group[2:0], func3[2:0]}
  localparam int ALU_CTRL_W = 6;
  localparam int ALU_GRP_W  = 3;
  localparam int ALU_FUNC_W = 3;

  localparam logic [ALU_GRP_W-1:0] ALU_GRP_MULDIV = 3'b100;

  localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_DIV  = 6'b100_100;
  localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_DIVU = 6'b100_101;
  localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_REM  = 6'b100_110;
  localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_REMU = 6'b100_111;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/ex_div_sequencer_div_step.sv
// rtl/ex_div_sequencer_div_step.sv - one combinational restoring shift-subtract step
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   i_rem,
  input  logic [XLEN-1:0] i_divisor,
  input  logic            i_dividend_bit,
  output logic [XLEN:0]   o_rem,
  output logic            o_q_bit
);

  logic [XLEN+1:0] w_shift;
  logic [XLEN:0]   w_diff;
  logic            w_borrow;

  // Shift in the next dividend bit, trial-subtract, keep the shifted value on borrow
  always_comb begin
    w_shift  = {i_rem, i_dividend_bit};
    w_borrow = (w_shift < {2'b00, i_divisor});
    w_diff   = w_shift[XLEN:0] - {1'b0, i_divisor};
    o_rem    = w_borrow ? w_shift[XLEN:0] : w_diff;
    o_q_bit  = ~w_borrow;
  end

endmodule

// File: rtl/ex_div_sequencer.sv
// rtl/ex_div_sequencer.sv - multi-cycle RV32M DIV/DIVU/REM/REMU sequencer for EX
module ex_div_sequencer
  import ex_div_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [ALU_CTRL_W-1:0] i_alu_ctrl,
  input  logic [XLEN-1:0]       i_op_a,
  input  logic [XLEN-1:0]       i_op_b,
  input  logic                  i_flush,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [XLEN-1:0]       o_result
);

  div_state_e      r_state;
  logic [XLEN-1:0] r_dividend;  // dividend bits shift out, quotient bits shift in
  logic [XLEN-1:0] r_divisor;
  logic [XLEN:0]   r_rem;
  logic [4:0]      r_cnt;
  logic            r_q_neg;
  logic            r_r_neg;
  logic            r_is_rem;
  logic [XLEN-1:0] r_result;

  logic            w_accept;
  logic            w_signed;
  logic            w_is_rem;
  logic            w_a_neg;
  logic            w_b_neg;
  logic            w_div_zero;
  logic            w_overflow;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic [XLEN:0]   w_step_rem;
  logic            w_step_q;
  logic [XLEN-1:0] w_fix_quot;
  logic [XLEN-1:0] w_fix_rem;

  // Decode the request and precompute the fast-path and magnitude operands
  always_comb begin
    w_accept   = i_start & (r_state == DIV_IDLE)
               & (i_alu_ctrl[ALU_CTRL_W-1:ALU_FUNC_W] == ALU_GRP_MULDIV)
               & i_alu_ctrl[2] & ~i_flush;
    w_signed   = ~i_alu_ctrl[0];
    w_is_rem   = i_alu_ctrl[1];
    w_a_neg    = w_signed & i_op_a[XLEN-1];
    w_b_neg    = w_signed & i_op_b[XLEN-1];
    w_div_zero = (i_op_b == '0);
    w_overflow = w_signed & (i_op_a == {1'b1, {(XLEN-1){1'b0}}}) & (i_op_b == '1);
    w_abs_a    = w_a_neg ? -i_op_a : i_op_a;
    w_abs_b    = w_b_neg ? -i_op_b : i_op_b;
    w_fix_quot = r_q_neg ? -r_dividend : r_dividend;
    w_fix_rem  = r_r_neg ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];
  end

  div_step #(.XLEN(XLEN)) u_div_step (
    .i_rem          (r_rem),
    .i_divisor      (r_divisor),
    .i_dividend_bit (r_dividend[XLEN-1]),
    .o_rem          (w_step_rem),
    .o_q_bit        (w_step_q)
  );

  // Sequencer: accept/fast path, 32 restoring steps, sign fix-up, one-cycle done
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= DIV_IDLE;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_is_rem   <= 1'b0;
      r_result   <= '0;
    end else if (i_flush) begin
      r_state <= DIV_IDLE;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (w_accept) begin
            r_is_rem <= w_is_rem;
            if (w_div_zero) begin
              r_result <= w_is_rem ? i_op_a : '1;
              r_state  <= DIV_DONE;
            end else if (w_overflow) begin
              r_result <= w_is_rem ? '0 : i_op_a;
              r_state  <= DIV_DONE;
            end else begin
              r_dividend <= w_abs_a;
              r_divisor  <= w_abs_b;
              r_q_neg    <= w_a_neg ^ w_b_neg;
              r_r_neg    <= w_a_neg;
              r_rem      <= '0;
              r_cnt      <= 5'd31;
              r_state    <= DIV_CALC;
            end
          end
        end
        DIV_CALC: begin
          r_rem      <= w_step_rem;
          r_dividend <= {r_dividend[XLEN-2:0], w_step_q};
          r_cnt      <= r_cnt - 5'd1;
          if (r_cnt == 5'd0) begin
            r_state <= DIV_FIX;
          end
        end
        DIV_FIX: begin
          r_result <= r_is_rem ? w_fix_rem : w_fix_quot;
          r_state  <= DIV_DONE;
        end
        default: begin
          r_state <= DIV_IDLE;
        end
      endcase
    end
  end

  // Stall covers the accept cycle itself; DONE releases the pipeline
  always_comb begin
    o_busy   = (r_state == DIV_CALC) | (r_state == DIV_FIX)
             | ((r_state == DIV_IDLE) & w_accept & i_rst_n);
    o_done   = (r_state == DIV_DONE);
    o_result = r_result;
  end

endmodule

// File: tb/tb_ex_div_sequencer.sv
// tb/tb_ex_div_sequencer.sv - self-checking bench for ex_div_sequencer
module tb_ex_div_sequencer;
  import ex_div_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex_div_sequencer #(.XLEN(32)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_alu_ctrl (alu_ctrl),
    .i_op_a     (op_a),
    .i_op_b     (op_b),
    .i_flush    (flush),
    .o_busy     (busy),
    .o_done     (done),
    .o_result   (result)
  );

  typedef struct {
    string       name;
    logic [5:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return c[1] ? a : 32'hFFFF_FFFF;
    if (!c[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return c[1] ? 32'd0 : 32'h8000_0000;
      return c[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return c[1] ? a % b : a / b;
  endfunction

  function automatic int ref_lat(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!c[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  task automatic run_op(input string name, input logic [5:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    logic [31:0] prev;
    prev = result;
    @(posedge clk); #1;
    start = 1'b1; alu_ctrl = c; op_a = a; op_b = b;
    @(negedge clk);
    check({name, " busy@N"}, 32'(busy), 32'd1);
    check({name, " done@N"}, 32'(done), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; alu_ctrl = 6'($urandom); op_a = $urandom; op_b = $urandom;
    for (int k = 1; k <= exp_lat + 1; k++) begin
      @(negedge clk);
      check($sformatf("%s busy@N+%0d", name, k), 32'(busy), 32'(k < exp_lat));
      check($sformatf("%s done@N+%0d", name, k), 32'(done), 32'(k == exp_lat));
      if (k < exp_lat) check($sformatf("%s held@N+%0d", name, k), result, prev);
      else             check($sformatf("%s result@N+%0d", name, k), result, exp_res);
    end
  endtask

  vec_t vecs[$];
  logic [31:0] prev_res;

  initial begin
    rst_n = 1'b0; start = 1'b0; alu_ctrl = '0; op_a = '0; op_b = '0; flush = 1'b0;

    vecs.push_back('{"divu_100_7",  ALU_CTRL_DIVU, 32'd100,         32'd7,           32'd14,          34});
    vecs.push_back('{"remu_100_7",  ALU_CTRL_REMU, 32'd100,         32'd7,           32'd2,           34});
    vecs.push_back('{"div_m7_2",    ALU_CTRL_DIV,  32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFD,   34});
    vecs.push_back('{"rem_m7_2",    ALU_CTRL_REM,  32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFF,   34});
    vecs.push_back('{"div_7_m2",    ALU_CTRL_DIV,  32'd7,           32'hFFFF_FFFE,   32'hFFFF_FFFD,   34});
    vecs.push_back('{"rem_7_m2",    ALU_CTRL_REM,  32'd7,           32'hFFFF_FFFE,   32'd1,           34});
    vecs.push_back('{"div_5_0",     ALU_CTRL_DIV,  32'd5,           32'd0,           32'hFFFF_FFFF,   1});
    vecs.push_back('{"remu_5_0",    ALU_CTRL_REMU, 32'd5,           32'd0,           32'd5,           1});
    vecs.push_back('{"div_ovf",     ALU_CTRL_DIV,  32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000,   1});
    vecs.push_back('{"rem_ovf",     ALU_CTRL_REM,  32'h8000_0000,   32'hFFFF_FFFF,   32'd0,           1});
    vecs.push_back('{"divu_ovfops", ALU_CTRL_DIVU, 32'h8000_0000,   32'hFFFF_FFFF,   32'd0,           34});
    vecs.push_back('{"remu_ovfops", ALU_CTRL_REMU, 32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000,   34});
    vecs.push_back('{"divu_max_1",  ALU_CTRL_DIVU, 32'hFFFF_FFFF,   32'd1,           32'hFFFF_FFFF,   34});
    vecs.push_back('{"div_m8_m3",   ALU_CTRL_DIV,  32'hFFFF_FFF8,   32'hFFFF_FFFD,   32'd2,           34});
    vecs.push_back('{"rem_m8_m3",   ALU_CTRL_REM,  32'hFFFF_FFF8,   32'hFFFF_FFFD,   32'hFFFF_FFFE,   34});

    // Reset state
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].name, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);
    end

    // Randomized operations against the arithmetic reference
    for (int i = 0; i < 30; i++) begin
      logic [5:0]  c;
      logic [31:0] a;
      logic [31:0] b;
      int          sel;
      c   = {4'b1001, 2'($urandom)};
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 5);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = $urandom_range(1, 15);
      else if (sel == 3) b = -$urandom_range(1, 15);
      run_op($sformatf("rand%0d", i), c, a, b, ref_result(c, a, b), ref_lat(c, a, b));
    end

    // Flush at N+10, new DIVU accepted at N+11 finishes at N+45
    prev_res = result;
    @(posedge clk); #1;
    start = 1'b1; alu_ctrl = ALU_CTRL_DIVU; op_a = 32'd1000; op_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check($sformatf("flush busy@N+%0d", k), 32'(busy), 32'd1);
      check($sformatf("flush done@N+%0d", k), 32'(done), 32'd0);
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    check("flush done@N+10", 32'(done), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    start = 1'b1; alu_ctrl = ALU_CTRL_DIVU; op_a = 32'd100; op_b = 32'd7;
    @(negedge clk);
    check("flush accept busy@N+11", 32'(busy), 32'd1);
    check("flush done@N+11", 32'(done), 32'd0);
    check("flush result kept", result, prev_res);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      check($sformatf("post-flush done@N+%0d", 11 + k), 32'(done), 32'(k == 34));
      check($sformatf("post-flush busy@N+%0d", 11 + k), 32'(busy), 32'(k < 34));
      if (k == 34) check("post-flush result", result, 32'd14);
    end

    // Asynchronous reset in the middle of CALC
    @(posedge clk); #1;
    start = 1'b1; alu_ctrl = ALU_CTRL_DIV; op_a = 32'd1000; op_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 15; k++) @(negedge clk);
    check("pre-reset busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset busy", 32'(busy), 32'd0);
    check("async reset done", 32'(done), 32'd0);
    check("async reset result", result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("after reset busy", 32'(busy), 32'd0);
    check("after reset done", 32'(done), 32'd0);
    run_op("after_reset_divu", ALU_CTRL_DIVU, 32'd100, 32'd7, 32'd14, 34);

    // Non-division codes and flush-with-start in IDLE must be ignored
    @(posedge clk); #1;
    start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      alu_ctrl = (k < 3) ? 6'b000_000 : 6'b100_011;
      @(negedge clk);
      check($sformatf("nondiv busy%0d", k), 32'(busy), 32'd0);
      check($sformatf("nondiv done%0d", k), 32'(done), 32'd0);
      @(posedge clk); #1;
    end
    alu_ctrl = ALU_CTRL_DIV; op_a = 32'd9; op_b = 32'd0; flush = 1'b1;
    @(negedge clk);
    check("flush+start busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("flush+start done%0d", k), 32'(done), 32'd0);
      check($sformatf("flush+start result%0d", k), result, 32'd14);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_div_sequencer.md
# ex_div_sequencer

Multi-cycle sequencer for RV32M division (DIV, DIVU, REM, REMU) in the EX stage of the 5-stage core.
- EX presents a decoded division with the ALU control code and both operands; the block stalls the pipeline while it iterates, then returns the result for one cycle.
- Uses a 32-step restoring shift-subtract.
- Division-by-zero and signed-overflow cases take a 1-cycle fast path.
- Sits beside the ALU. Its result is muxed into the EX result path when `done` is high.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  core clock; everything is sampled on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  EX holds a valid instruction for this block.
- alu_ctrl  in  6  ALU control code; division is {3'b100, func3} with func3 in 100..111.
- op_a  in  32  dividend (rs1).
- op_b  in  32  divisor (rs2).
- flush  in  1  pipeline flush; aborts any operation in progress.
- busy  out  1  stall request to the hazard unit.
- done  out  1  result valid, one-cycle pulse.
- result  out  32  quotient or remainder; registered and held until the next completion.

## Operation
- **Accept condition:** accept = start & (state==IDLE) & (alu_ctrl[5:3]==3'b100) & alu_ctrl[2] & ~flush. With start=1 and any other alu_ctrl, there is no effect.
- **Op decode** from alu_ctrl[1:0]:
  - 00 DIV, 01 DIVU: result = quotient.
  - 10 REM, 11 REMU: result = remainder.
  - Signed when alu_ctrl[0]==0.
- **FSM:** IDLE, CALC, FIX, DONE.
- **IDLE:**
  - On accept with op_b==0 → DONE. Result = 32'hFFFF_FFFF for a quotient, op_a for a remainder.
  - On accept with signed op, op_a==32'h8000_0000 and op_b==32'hFFFF_FFFF → DONE. Result = 32'h8000_0000 for DIV, 0 for REM.
  - Any other accept → CALC. Latch |op_a| and |op_b| (raw values if unsigned), the quotient sign (a_sign ^ b_sign) and the remainder sign (a_sign). Clear the 33-bit partial remainder and the 5-bit counter (counter = 31).
- **CALC:**
  - One restoring step per cycle: shift the remainder left, bringing in the dividend MSB; trial-subtract the divisor; set the quotient bit to ~borrow; restore on borrow.
  - Counter decrements each cycle. After the step with counter==0 → FIX. CALC lasts exactly 32 cycles.
- **FIX:** negate the quotient and/or remainder per the latched signs, write `result`, go to DONE.
- **DONE:** done=1 for this cycle; unconditionally → IDLE.
- **busy:** high when (state==CALC or FIX) or (state==IDLE & accept). Low in DONE, so the pipeline advances while the result is presented.
- **Flush:** in any state, flush=1 → IDLE on the next edge; done is not asserted and result keeps its previous value. If flush and start occur in the same IDLE cycle, flush wins.
- **Reset:** rst_n low forces state=IDLE, result=0, done=0, busy=0 immediately, including mid-CALC.

## Timing
- Accept in cycle N, normal path:
  - busy=1 in cycles N..N+33.
  - CALC occupies N+1..N+32; FIX is N+33.
  - done=1 and result valid in N+34.
- Fast path: busy=1 in N only; done=1 in N+1.
- A back-to-back division is accepted at the earliest in the cycle after DONE (IDLE).
- busy has a combinational path from start/alu_ctrl. All other outputs are registered.
- While busy=1, operand and ctrl inputs are don't-care; latched copies are used.

## Structure
- Shared core package gets:
  - State enum `div_state_e`.
  - Constants ALU_CTRL_DIV=6'b100_100, ALU_CTRL_DIVU=6'b100_101, ALU_CTRL_REM=6'b100_110, ALU_CTRL_REMU=6'b100_111.
  - Field widths for alu_ctrl.
- One sub-module, `div_step`: combinational single restoring step (33-bit remainder, divisor, dividend bit in → next remainder, quotient bit out). The FSM, counter, sign handling and output registers stay in `ex_div_sequencer`.

## Test plan
- DIVU 100/7 accepted at N → busy 1 for N..N+33, done in N+34 only, result=14; REMU same operands → 2.
- DIV -7/2 → 32'hFFFF_FFFD; REM -7/2 → 32'hFFFF_FFFF; DIV 7/-2 → 32'hFFFF_FFFD; REM 7/-2 → 1.
- DIV 5/0 → done at N+1, result 32'hFFFF_FFFF; REMU 5/0 → 5; busy high for cycle N only.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF → done at N+1, result 32'h8000_0000; REM → 0; DIVU with the same operands takes the full 34 cycles, result 0.
- Flush at N+10 of a DIVU → IDLE at N+11, done never asserted, result unchanged; new DIVU started at N+11 completes at N+45.
- rst_n low at N+15 of a division → busy, done, result go to 0 asynchronously. Separately, start=1 with alu_ctrl=6'b000_000 → busy stays 0 and done never asserts.
